// File: rtl/game_round_fsm.sv
// Multi-round game controller.
// Sequences IDLE -> COUNTDOWN -> RUNNING -> ROUND_END ... -> FINISH. It has an
// internal seconds prescaler, pause/resume, and registered display outputs
// (state code, seconds remaining, round number) plus one-cycle event pulses.
module game_round_fsm #(
  parameter int CLK_HZ            = 100000000,
  parameter int GAME_SECONDS      = 30,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int NUM_ROUNDS        = 3
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       startGame,
  input  logic       pauseBtn,
  output logic       game_active,
  output logic [2:0] fsm_state,
  output logic [5:0] time_left,
  output logic [3:0] round_num,
  output logic       sec_tick,
  output logic       round_done,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUNNING   = 3'd2,
    S_PAUSED    = 3'd3,
    S_ROUND_END = 3'd4,
    S_FINISH    = 3'd5
  } state_e;

  // A one-cycle-per-second clock still needs a 1-bit prescaler.
  localparam int              PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [5:0]      GAME_T      = 6'(GAME_SECONDS);
  localparam logic [5:0]      COUNT_T     = 6'(COUNTDOWN_SECONDS);
  localparam logic [3:0]      ROUNDS_T    = 4'(NUM_ROUNDS);
  // With a zero-length countdown, a round starts straight in RUNNING.
  localparam state_e          ENTRY_STATE = (COUNTDOWN_SECONDS == 0) ? S_RUNNING : S_COUNTDOWN;
  localparam logic [5:0]      ENTRY_TIME  = (COUNTDOWN_SECONDS == 0) ? GAME_T : COUNT_T;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    time_q, time_d;
  logic [3:0]    round_q, round_d;
  logic          active_q, active_d;
  logic          sec_tick_q, sec_tick_d;
  logic          round_done_q, round_done_d;
  logic          game_over_q, game_over_d;

  logic counting;
  logic tick;

  // The prescaler runs only while a countdown or round is in progress.
  assign counting = (state_q == S_COUNTDOWN) || (state_q == S_RUNNING);
  assign tick     = counting && (presc_q == PRESC_LAST);

  // Next-state, timer, round and pulse logic.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d      = state_q;
    presc_d      = presc_q;
    time_d       = time_q;
    round_d      = round_q;
    sec_tick_d   = 1'b0;
    round_done_d = 1'b0;
    game_over_d  = 1'b0;

    if (counting) begin
      presc_d    = tick ? '0 : presc_q + PW'(1);
      sec_tick_d = tick;
    end

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (startGame) begin
          state_d = ENTRY_STATE;
          time_d  = ENTRY_TIME;
          round_d = 4'd1;
          presc_d = '0;
        end
      end

      S_COUNTDOWN: begin
        if (tick) begin
          if (time_q <= 6'd1) begin
            state_d = S_RUNNING;
            time_d  = GAME_T;
            presc_d = '0;
          end else begin
            time_d = time_q - 6'd1;
          end
        end
      end

      S_RUNNING: begin
        if (tick && (time_q <= 6'd1)) begin
          // Expiry wins over a coincident pause request.
          time_d       = 6'd0;
          round_done_d = 1'b1;
          if (round_q >= ROUNDS_T) begin
            state_d     = S_FINISH;
            game_over_d = 1'b1;
          end else begin
            state_d = S_ROUND_END;
          end
        end else begin
          if (tick) begin
            time_d = time_q - 6'd1;
          end
          if (pauseBtn) begin
            state_d = S_PAUSED;
          end
        end
      end

      S_PAUSED: begin
        // Prescaler and timer are left untouched, so resume continues mid-second.
        if (pauseBtn) begin
          state_d = S_RUNNING;
        end
      end

      S_ROUND_END: begin
        time_d = 6'd0;
        if (startGame) begin
          state_d = ENTRY_STATE;
          time_d  = ENTRY_TIME;
          round_d = (round_q < ROUNDS_T) ? round_q + 4'd1 : ROUNDS_T;
          presc_d = '0;
        end
      end

      default: begin
        // Unused codes 6 and 7 recover to a clean idle.
        state_d = S_IDLE;
        time_d  = GAME_T;
        round_d = 4'd0;
        presc_d = '0;
      end
    endcase

    active_d = (state_d == S_RUNNING);
  end

  // State and registered outputs, with synchronous reset taking priority.
  always_ff @(posedge clkIn) begin
    // NOTE: non-blocking assignments here, so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      time_q       <= GAME_T;
      round_q      <= 4'd0;
      active_q     <= 1'b0;
      sec_tick_q   <= 1'b0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
      round_q      <= round_d;
      active_q     <= active_d;
      sec_tick_q   <= sec_tick_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
    end
  end

  assign game_active = active_q;
  assign fsm_state   = state_q;
  assign time_left   = time_q;
  assign round_num   = round_q;
  assign sec_tick    = sec_tick_q;
  assign round_done  = round_done_q;
  assign game_over   = game_over_q;

endmodule
